// File: rtl/pcie_tl_tx_pkg.sv
// pcie_tl_tx_pkg: shared TLP sizes, header layout, FSM states and header builder for the TL transmit path
package pcie_tl_tx_pkg;
  localparam int PCIe_DATA_PAYLOAD_SIZE = 128;
  localparam int PCIe_TL_TLP_PACKET_SIZE = 224;
  localparam logic [2:0] FMT_MWR_3DW = 3'b010;
  localparam logic [4:0] TYPE_MEM = 5'b00000;
  typedef enum logic [1:0] {COLLECT, PUSH, RESP} req_state_t;
  typedef struct packed {
    logic [2:0] fmt;
    logic [4:0] typ;
    logic r0;
    logic [2:0] tc;
    logic [9:0] flags;
    logic [9:0] length;
    logic [15:0] req_id;
    logic [7:0] tag;
    logic [3:0] last_be;
    logic [3:0] first_be;
    logic [29:0] addr;
    logic [1:0] r1;
  } tlp_memory_header;
  // Low address bits are dword-aligned away: they always read back as zero.
  function automatic tlp_memory_header build_header(input logic [31:0] addr, input logic [2:0] tc,
                                                    input logic [7:0] tag, input logic [15:0] req_id);
    build_header = '{fmt: FMT_MWR_3DW, typ: TYPE_MEM, r0: 1'b0, tc: tc, flags: '0, length: 10'd4,
                     req_id: req_id, tag: tag, last_be: 4'hF, first_be: 4'hF,
                     addr: addr[31:2], r1: addr[1:0] & 2'b00};
  endfunction
endpackage

// File: rtl/pcie_tl_tx_fifo.sv
// pcie_tl_tx_fifo: show-ahead synchronous FIFO (DEPTH power of two), sync active-low reset
//   clk, rst_n      clock and synchronous active-low reset
//   wr_en, wdata    write port (ignored when full)
//   rd_en, rdata    read port; rdata is the head entry whenever !empty
//   full, empty     occupancy flags
module pcie_tl_tx_fifo #(
  parameter int WIDTH = 224,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic wr, rd;
  assign wr = wr_en && !full;
  assign rd = rd_en && !empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rptr];
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= wdata;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(wr);
      rptr <= rptr + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/pcie_tl_tx.sv
// pcie_tl_tx: AXI write requests -> 3DW MWr TLPs, per-VC queues, credit-gated round-robin to the DLL
//   clk, rst                      clock, synchronous active-high reset
//   aw*/w*/b*                     AXI-style write address, data and response channels
//   fc_valid_i[1:0]               per-VC credit return pulses
//   tlp_valid_o, tlp_o, tlp_ready_i  {header[95:0], payload[127:0]} towards the DLL
module pcie_tl_tx
  import pcie_tl_tx_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter logic [15:0] REQ_ID = 16'h0100
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               awvalid_i,
  output logic                               awready_o,
  input  logic [31:0]                        awaddr_i,
  input  logic [2:0]                         awqos_i,
  input  logic                               wvalid_i,
  output logic                               wready_o,
  input  logic [PCIe_DATA_PAYLOAD_SIZE-1:0]  wdata_i,
  output logic                               bvalid_o,
  input  logic                               bready_i,
  input  logic [1:0]                         fc_valid_i,
  output logic                               tlp_valid_o,
  output logic [PCIe_TL_TLP_PACKET_SIZE-1:0] tlp_o,
  input  logic                               tlp_ready_i
);
  localparam int CW = $clog2(CREDITS + 1);
  req_state_t state, state_nx;
  logic aw_held, w_held, aw_fire, w_fire, push, rr, sel, out_free;
  logic [31:0] addr_q;
  logic [2:0] qos_q;
  logic [PCIe_DATA_PAYLOAD_SIZE-1:0] data_q;
  logic [7:0] tag;
  logic [1:0] wr_en, full, empty, elig, pop;
  logic [PCIe_TL_TLP_PACKET_SIZE-1:0] entry;
  logic [PCIe_TL_TLP_PACKET_SIZE-1:0] rdata [2];
  logic [CW-1:0] credit [2];
  assign aw_fire = awvalid_i && awready_o;
  assign w_fire = wvalid_i && wready_o;
  assign push = state == PUSH && !full[qos_q[0]];
  assign wr_en = push ? (qos_q[0] ? 2'b10 : 2'b01) : 2'b00;
  assign entry = {build_header(addr_q, qos_q, tag, REQ_ID), data_q};
  always_ff @(posedge clk)
    state <= rst ? COLLECT : state_nx;
  always_comb begin
    state_nx = state;
    // Both channels may land on the same edge, so the held flags alone would lag by a cycle.
    if (state == COLLECT && (aw_held || aw_fire) && (w_held || w_fire)) state_nx = PUSH;
    if (state == PUSH && push) state_nx = RESP;
    if (state == RESP && bready_i) state_nx = COLLECT;
  end
  always_comb begin
    awready_o = !rst && state == COLLECT && !aw_held;
    wready_o = !rst && state == COLLECT && !w_held;
    bvalid_o = state == RESP;
  end
  always_ff @(posedge clk)
    if (rst) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
      tag <= '0;
    end else begin
      if (aw_fire) begin
        aw_held <= 1'b1;
        addr_q <= awaddr_i;
        qos_q <= awqos_i;
      end
      if (w_fire) begin
        w_held <= 1'b1;
        data_q <= wdata_i;
      end
      if (push) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        tag <= tag + 8'd1;
      end
    end
  for (genvar v = 0; v < 2; v++) begin : g_vc
    assign elig[v] = !empty[v] && credit[v] != '0;
    pcie_tl_tx_fifo #(.WIDTH(PCIe_TL_TLP_PACKET_SIZE), .DEPTH(4)) u_fifo (
      .clk(clk), .rst_n(!rst), .wr_en(wr_en[v]), .wdata(entry),
      .rd_en(pop[v]), .rdata(rdata[v]), .full(full[v]), .empty(empty[v])
    );
  end
  assign out_free = !tlp_valid_o || tlp_ready_i;
  assign sel = elig[rr] ? rr : !rr;
  assign pop = (out_free && |elig) ? (sel ? 2'b10 : 2'b01) : 2'b00;
  always_ff @(posedge clk)
    if (rst) begin
      rr <= 1'b0;
      tlp_valid_o <= 1'b0;
      tlp_o <= '0;
    end else if (|pop) begin
      rr <= !sel;
      tlp_valid_o <= 1'b1;
      tlp_o <= rdata[sel];
    end else if (tlp_ready_i) begin
      tlp_valid_o <= 1'b0;
    end
  // A pop and a return in the same cycle cancel; returns saturate at CREDITS.
  always_ff @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (rst) credit[i] <= CW'(CREDITS);
      else if (pop[i] && !fc_valid_i[i]) credit[i] <= credit[i] - CW'(1);
      else if (!pop[i] && fc_valid_i[i] && credit[i] != CW'(CREDITS)) credit[i] <= credit[i] + CW'(1);
endmodule

// File: tb/tb_pcie_tl_tx.sv
// tb_pcie_tl_tx: directed self-checking bench for pcie_tl_tx
module tb_pcie_tl_tx;
  logic clk = 1'b0, rst = 1'b1;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, tlp_ready = 1'b0;
  logic awready, wready, bvalid, tlp_valid;
  logic [31:0] awaddr = '0;
  logic [2:0] awqos = '0;
  logic [127:0] wdata = '0;
  logic [1:0] fc_valid = '0;
  logic [223:0] tlp;
  int errors = 0, checks = 0, cyc = 0;
  logic [223:0] got [$];
  int got_cyc [$];

  pcie_tl_tx #(.CREDITS(4), .REQ_ID(16'h0100)) dut (
    .clk(clk), .rst(rst), .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr),
    .awqos_i(awqos), .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata),
    .bvalid_o(bvalid), .bready_i(bready), .fc_valid_i(fc_valid),
    .tlp_valid_o(tlp_valid), .tlp_o(tlp), .tlp_ready_i(tlp_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (!rst && tlp_valid && tlp_ready) begin
      got.push_back(tlp);
      got_cyc.push_back(cyc);
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1; awvalid = 0; wvalid = 0; fc_valid = 0; tlp_ready = 0; bready = 1;
    repeat (2) @(negedge clk);
    got.delete();
    got_cyc.delete();
    rst = 0;
  endtask

  task automatic send(input logic [31:0] a, input logic [2:0] q, input logic [127:0] d);
    int n = 0;
    logic aw_go, w_go;
    @(negedge clk);
    awvalid = 1; awaddr = a; awqos = q; wvalid = 1; wdata = d;
    while ((awvalid || wvalid) && n < 50) begin
      aw_go = awvalid && awready;
      w_go = wvalid && wready;
      @(negedge clk);
      if (aw_go) awvalid = 0;
      if (w_go) wvalid = 0;
      n++;
    end
    checks++;
    if (awvalid || wvalid) begin
      errors++;
      $display("FAIL send_accept: request %h not accepted within 50 cycles", a);
      awvalid = 0; wvalid = 0;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++; if (awready !== 1'b0) begin errors++; $display("FAIL rst_awready got=%b exp=0", awready); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL rst_wready got=%b exp=0", wready); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid got=%b exp=0", bvalid); end
    checks++; if (tlp_valid !== 1'b0) begin errors++; $display("FAIL rst_tlp_valid got=%b exp=0", tlp_valid); end
    checks++; if (tlp !== 224'd0) begin errors++; $display("FAIL rst_tlp got=%h exp=0", tlp); end
    rst = 0;
    #1;
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL post_rst_awready got=%b exp=1", awready); end
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL post_rst_wready got=%b exp=1", wready); end
  endtask

  task automatic test_single_write;
    logic [223:0] t;
    logic [127:0] pat;
    pat = {4{32'hA5A5_A5A5}};
    do_reset();
    send(32'h0000_1004, 3'd0, pat);
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL sw_bvalid_t0 got=%b exp=0", bvalid); end
    @(negedge clk);
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL sw_bvalid_t1 got=%b exp=1", bvalid); end
    checks++; if (tlp_valid !== 1'b0) begin errors++; $display("FAIL sw_tlp_valid_t1 got=%b exp=0", tlp_valid); end
    @(negedge clk);
    checks++; if (tlp_valid !== 1'b1) begin errors++; $display("FAIL sw_tlp_valid_t2 got=%b exp=1", tlp_valid); end
    checks++; if (tlp[223:192] !== 32'h4000_0004) begin errors++; $display("FAIL sw_dw0 got=%h exp=40000004", tlp[223:192]); end
    checks++; if (tlp[191:160] !== 32'h0100_00FF) begin errors++; $display("FAIL sw_dw1 got=%h exp=010000ff", tlp[191:160]); end
    checks++; if (tlp[159:128] !== 32'h0000_1004) begin errors++; $display("FAIL sw_dw2 got=%h exp=00001004", tlp[159:128]); end
    checks++; if (tlp[127:0] !== pat) begin errors++; $display("FAIL sw_payload got=%h exp=%h", tlp[127:0], pat); end
    tlp_ready = 1;
    send(32'h0000_2003, 3'd0, 128'h1234);
    repeat (6) @(negedge clk);
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL sw_count got=%0d exp=2", got.size()); end
    if (got.size() >= 2) begin
      t = got[1];
      checks++; if (t[175:168] !== 8'd1) begin errors++; $display("FAIL sw_tag2 got=%0d exp=1", t[175:168]); end
      checks++; if (t[159:128] !== 32'h0000_2000) begin errors++; $display("FAIL sw_dw2_align got=%h exp=00002000", t[159:128]); end
    end
  endtask

  task automatic test_w_before_aw;
    logic [223:0] t;
    do_reset();
    tlp_ready = 1;
    @(negedge clk);
    wvalid = 1; wdata = 128'hBEEF_0001;
    @(negedge clk);
    wvalid = 0;
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL wa_wready_held got=%b exp=0", wready); end
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL wa_awready got=%b exp=1", awready); end
    @(negedge clk);
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL wa_wready_held2 got=%b exp=0", wready); end
    awvalid = 1; awaddr = 32'h0000_0040; awqos = 3'd1;
    @(negedge clk);
    awvalid = 0;
    repeat (6) @(negedge clk);
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL wa_count got=%0d exp=1", got.size()); end
    if (got.size() >= 1) begin
      t = got[0];
      checks++; if (t[223:192] !== 32'h4010_0004) begin errors++; $display("FAIL wa_dw0 got=%h exp=40100004", t[223:192]); end
      checks++; if (t[127:0] !== 128'hBEEF_0001) begin errors++; $display("FAIL wa_payload got=%h exp=beef0001", t[127:0]); end
    end
  endtask

  task automatic test_round_robin;
    logic [223:0] t;
    logic [127:0] exp_p [6];
    exp_p = '{128'h10, 128'h20, 128'h11, 128'h21, 128'h12, 128'h22};
    do_reset();
    for (int i = 0; i < 3; i++) send(32'h100 + 32'(i * 16), 3'd0, 128'h10 + 128'(i));
    for (int i = 0; i < 3; i++) send(32'h200 + 32'(i * 16), 3'd1, 128'h20 + 128'(i));
    @(negedge clk);
    tlp_ready = 1;
    repeat (10) @(negedge clk);
    checks++; if (got.size() !== 6) begin errors++; $display("FAIL rr_count got=%0d exp=6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      t = got[i];
      checks++; if (t[127:0] !== exp_p[i]) begin errors++; $display("FAIL rr_order[%0d] got=%h exp=%h", i, t[127:0], exp_p[i]); end
      checks++; if (got_cyc[i] - got_cyc[0] !== i) begin errors++; $display("FAIL rr_gap[%0d] got=%0d exp=%0d", i, got_cyc[i] - got_cyc[0], i); end
    end
  endtask

  task automatic test_credits;
    logic [223:0] t;
    do_reset();
    tlp_ready = 1;
    for (int i = 0; i < 6; i++) send(32'h300, 3'd0, 128'h30 + 128'(i));
    repeat (8) @(negedge clk);
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL cr_block got=%0d exp=4", got.size()); end
    fc_valid = 2'b01;
    @(negedge clk);
    fc_valid = 2'b00;
    repeat (4) @(negedge clk);
    checks++; if (got.size() !== 5) begin errors++; $display("FAIL cr_return got=%0d exp=5", got.size()); end
    if (got.size() >= 5) begin
      t = got[4];
      checks++; if (t[127:0] !== 128'h34) begin errors++; $display("FAIL cr_fifth got=%h exp=34", t[127:0]); end
    end
    fc_valid = 2'b01;
    repeat (2) @(negedge clk);
    fc_valid = 2'b00;
    repeat (4) @(negedge clk);
    send(32'h300, 3'd0, 128'h36);
    send(32'h300, 3'd0, 128'h37);
    repeat (6) @(negedge clk);
    checks++; if (got.size() !== 7) begin errors++; $display("FAIL cr_simul got=%0d exp=7", got.size()); end
    fc_valid = 2'b01;
    @(negedge clk);
    fc_valid = 2'b00;
    repeat (4) @(negedge clk);
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL cr_drain got=%0d exp=8", got.size()); end
    fc_valid = 2'b01;
    repeat (8) @(negedge clk);
    fc_valid = 2'b00;
    for (int i = 0; i < 6; i++) send(32'h300, 3'd0, 128'h40 + 128'(i));
    repeat (8) @(negedge clk);
    checks++; if (got.size() !== 12) begin errors++; $display("FAIL cr_saturate got=%0d exp=12", got.size()); end
  endtask

  task automatic test_backpressure;
    logic [223:0] first, t;
    do_reset();
    for (int i = 0; i < 6; i++) send(32'h500, 3'd0, 128'h50 + 128'(i));
    first = tlp;
    checks++; if (first[127:0] !== 128'h50) begin errors++; $display("FAIL bp_head got=%h exp=50", first[127:0]); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (tlp !== first || tlp_valid !== 1'b1 || awready !== 1'b0 || bvalid !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall[%0d] got valid=%b awready=%b bvalid=%b tlp=%h exp valid=1 awready=0 bvalid=0 tlp=%h",
                 i, tlp_valid, awready, bvalid, tlp, first);
      end
    end
    fc_valid = 2'b01;
    tlp_ready = 1;
    repeat (12) @(negedge clk);
    fc_valid = 2'b00;
    checks++; if (got.size() !== 6) begin errors++; $display("FAIL bp_count got=%0d exp=6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      t = got[i];
      checks++; if (t[127:0] !== 128'h50 + 128'(i)) begin errors++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, t[127:0], 128'h50 + 128'(i)); end
    end
  endtask

  task automatic test_reset_traffic;
    logic [223:0] t;
    do_reset();
    for (int i = 0; i < 3; i++) send(32'h600, 3'd0, 128'h60 + 128'(i));
    awvalid = 1; awaddr = 32'h700; awqos = 3'd0;
    @(negedge clk);
    rst = 1; awvalid = 0;
    @(negedge clk);
    checks++; if (tlp_valid !== 1'b0) begin errors++; $display("FAIL rt_tlp_valid got=%b exp=0", tlp_valid); end
    checks++; if (tlp !== 224'd0) begin errors++; $display("FAIL rt_tlp got=%h exp=0", tlp); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL rt_bvalid got=%b exp=0", bvalid); end
    checks++; if (awready !== 1'b0 || wready !== 1'b0) begin errors++; $display("FAIL rt_ready got=%b%b exp=00", awready, wready); end
    got.delete();
    got_cyc.delete();
    rst = 0;
    #1;
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL rt_awready got=%b exp=1", awready); end
    tlp_ready = 1;
    for (int i = 0; i < 4; i++) send(32'h800, 3'd0, 128'h80 + 128'(i));
    repeat (8) @(negedge clk);
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL rt_count got=%0d exp=4", got.size()); end
    if (got.size() >= 4) begin
      t = got[0];
      checks++; if (t[175:168] !== 8'd0) begin errors++; $display("FAIL rt_tag0 got=%0d exp=0", t[175:168]); end
      checks++; if (t[127:0] !== 128'h80) begin errors++; $display("FAIL rt_first got=%h exp=80", t[127:0]); end
      t = got[3];
      checks++; if (t[175:168] !== 8'd3) begin errors++; $display("FAIL rt_tag3 got=%0d exp=3", t[175:168]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_w_before_aw();
    test_round_robin();
    test_credits();
    test_backpressure();
    test_reset_traffic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
